// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window controller.
//   SOBEL_DW     : pixel width, must match the Sobel core input width
//   SOBEL_IMG_W  : default frame width in pixels
//   SOBEL_IMG_H  : default frame height in lines
//   state_e      : controller FSM states
//   win_count()  : number of interior 3x3 windows in a frame
package sobel_pkg;

    localparam int SOBEL_DW    = 8;
    localparam int SOBEL_IMG_W = 64;
    localparam int SOBEL_IMG_H = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Border pixels have no full 3x3 neighbourhood, so only the interior
    // (w-2) x (h-2) positions produce a window.
    function automatic int win_count(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel storage, indexed by column.
//   clk   : clock
//   we    : write enable (one pixel per accepted input)
//   addr  : column index, shared by read and write
//   wdata : pixel to store at addr
//   rdata : combinational read of addr (value before this cycle's write)
// Contents are intentionally not reset; the controller never emits data
// from a line that has not been written in the current frame.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = SOBEL_IMG_W,
    parameter int DW    = SOBEL_DW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequences a 3x3 Sobel core over one raster-order frame.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i             : start-of-frame pulse, honoured only in IDLE
//   pix_i, pix_valid_i  : incoming pixel stream
//   pix_ready_o         : high while the frame is being streamed
//   data_r_c_o          : 3x3 window (row r top->bottom, col c left->right)
//   core_en_o           : one-cycle strobe per interior window
//   pixel_en_i          : result strobe from the core
//   busy_o              : frame in progress
//   done_o              : one-cycle pulse after the last result
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = SOBEL_IMG_W,
    parameter int IMG_H = SOBEL_IMG_H,
    parameter int DW    = SOBEL_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [DW-1:0] pix_i,
    input  logic          pix_valid_i,
    output logic          pix_ready_o,
    output logic [DW-1:0] data_0_0_o,
    output logic [DW-1:0] data_0_1_o,
    output logic [DW-1:0] data_0_2_o,
    output logic [DW-1:0] data_1_0_o,
    output logic [DW-1:0] data_1_1_o,
    output logic [DW-1:0] data_1_2_o,
    output logic [DW-1:0] data_2_0_o,
    output logic [DW-1:0] data_2_1_o,
    output logic [DW-1:0] data_2_2_o,
    output logic          core_en_o,
    input  logic          pixel_en_i,
    output logic          busy_o,
    output logic          done_o
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int N_WIN = win_count(IMG_W, IMG_H);
    localparam int NW    = $clog2(N_WIN + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [NW-1:0] RES_LAST = NW'(N_WIN);

    state_e          state_reg, state_next;
    logic [CW-1:0]   col_reg;
    logic [RW-1:0]   row_reg;
    logic [NW-1:0]   res_cnt_reg;
    logic            core_en_reg;
    logic            accept;
    logic            last_pix;
    logic [DW-1:0]   lb0_rd, lb1_rd;
    logic [2:0][DW-1:0]       new_col;
    logic [2:0][2:0][DW-1:0]  win;

    assign accept   = pix_valid_i && (state_reg == STREAM);
    assign last_pix = accept && (col_reg == COL_LAST) && (row_reg == ROW_LAST);

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i)                 state_next = STREAM;
            STREAM:  if (last_pix)                state_next = DRAIN;
            DRAIN:   if (res_cnt_reg == RES_LAST) state_next = DONE;
            DONE:                                 state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // Position counters, result counter and window strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg     <= '0;
            row_reg     <= '0;
            res_cnt_reg <= '0;
            core_en_reg <= 1'b0;
        end else begin
            // A window is complete only once two full lines are buffered and
            // two columns of the current line have arrived, so it can never
            // straddle a line wrap or use stale line-buffer content.
            core_en_reg <= accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
            if (state_reg == IDLE) begin
                if (start_i) begin
                    col_reg     <= '0;
                    row_reg     <= '0;
                    res_cnt_reg <= '0;
                end
            end else begin
                if (accept) begin
                    if (col_reg == COL_LAST) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 1'b1;
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
                if (pixel_en_i && (state_reg == STREAM || state_reg == DRAIN)) begin
                    res_cnt_reg <= res_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Two line buffers: lb0 = two lines back, lb1 = previous line.
    // On accept the column shifts up: lb0 takes lb1's old value, lb1 the new pixel.
    sobel_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_reg),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_reg),
        .wdata (pix_i),
        .rdata (lb1_rd)
    );

    assign new_col[0] = lb0_rd;
    assign new_col[1] = lb1_rd;
    assign new_col[2] = pix_i;

    // One three-tap shift register per window row; tap 0 is the oldest column.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [2:0][DW-1:0] tap_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tap_reg <= '0;
            end else if (accept) begin
                tap_reg <= {new_col[gi], tap_reg[2:1]};
            end
        end

        assign win[gi] = tap_reg;
    end

    assign data_0_0_o  = win[0][0];
    assign data_0_1_o  = win[0][1];
    assign data_0_2_o  = win[0][2];
    assign data_1_0_o  = win[1][0];
    assign data_1_1_o  = win[1][1];
    assign data_1_2_o  = win[1][2];
    assign data_2_0_o  = win[2][0];
    assign data_2_1_o  = win[2][1];
    assign data_2_2_o  = win[2][2];

    assign core_en_o   = core_en_reg;
    assign pix_ready_o = (state_reg == STREAM);
    assign busy_o      = (state_reg != IDLE);
    assign done_o      = (state_reg == DONE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 4x4 frame.
// The stimulus side pushes each expected 3x3 window (cut straight out of the
// frame array) when the pixel completing it is accepted; a monitor compares
// every core_en_o window against the queue head. A one-cycle delay of
// core_en_o stands in for the Sobel core's pixel_en_o.
module tb_sobel_window_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] pix_i = '0;
    logic          pix_valid_i = 1'b0;
    logic          pix_ready_o;
    logic [DW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
    logic          core_en_o;
    logic          pixel_en_i;
    logic          busy_o;
    logic          done_o;

    logic [9*DW-1:0] win_bus;
    assign win_bus = {d00, d01, d02, d10, d11, d12, d20, d21, d22};

    always #5 clk = ~clk;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .pix_i       (pix_i),
        .pix_valid_i (pix_valid_i),
        .pix_ready_o (pix_ready_o),
        .data_0_0_o  (d00),
        .data_0_1_o  (d01),
        .data_0_2_o  (d02),
        .data_1_0_o  (d10),
        .data_1_1_o  (d11),
        .data_1_2_o  (d12),
        .data_2_0_o  (d20),
        .data_2_1_o  (d21),
        .data_2_2_o  (d22),
        .core_en_o   (core_en_o),
        .pixel_en_i  (pixel_en_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Core stand-in: one result strobe one cycle after each enable
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pixel_en_i <= 1'b0;
        else        pixel_en_i <= core_en_o;
    end

    int              tests = 0;
    int              fails = 0;
    logic [DW-1:0]   frame [NP];
    logic [9*DW-1:0] exp_q [$];
    logic [9*DW-1:0] seen_q [$];
    int              en_seen = 0;
    int              done_seen = 0;
    int              cyc = 0;
    int              pen_cyc = 0;
    int              done_cyc = 0;

    task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] ref_window(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(8 - (3 * i + j)) * DW +: DW] = frame[(r - 2 + i) * W + (c - 2 + j)];
        return w;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_pct);
        int t;
        for (int idx = lo; idx < hi; idx++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                pix_valid_i = 1'b0;
                pix_i = DW'($urandom);
                @(posedge clk); #1;
            end
            pix_i = frame[idx];
            pix_valid_i = 1'b1;
            t = 0;
            @(negedge clk);
            while (!pix_ready_o && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!pix_ready_o) chk("accept_timeout", 0, 1);
            if (idx / W >= 2 && idx % W >= 2) exp_q.push_back(ref_window(idx / W, idx % W));
            @(posedge clk); #1;
            $display("[TB] pixel %0d (r%0d c%0d) = %0h accepted", idx, idx / W, idx % W, frame[idx]);
        end
        pix_valid_i = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int en0, input int done0);
        int t;
        t = 0;
        while (done_seen == done0 && t < 200) begin
            @(posedge clk); #3;
            t++;
        end
        chk({tag, "_done_seen"}, (done_seen > done0) ? 1 : 0, 1);
        chk({tag, "_busy_after"}, busy_o, 0);
        chk({tag, "_done_one_cycle"}, done_o, 0);
        chk({tag, "_enables"}, en_seen - en0, (W - 2) * (H - 2));
        chk({tag, "_done_count"}, done_seen - done0, 1);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_done_latency"}, done_cyc - pen_cyc, 2);
        $display("[TB] frame %s complete: %0d enables, %0d done pulses", tag, en_seen - en0, done_seen - done0);
    endtask

    initial begin
        int en0, done0;

        // Monitor: runs on the falling edge, away from DUT updates
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst_n) begin
                    if (pixel_en_i) pen_cyc = cyc;
                    if (done_o) begin
                        done_seen++;
                        done_cyc = cyc;
                    end
                    if (core_en_o) begin
                        en_seen++;
                        seen_q.push_back(win_bus);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_core_en", 1, 0);
                        end else begin
                            chk("window", win_bus, exp_q.pop_front());
                        end
                        $display("[TB] window %0h", win_bus);
                    end
                end
            end
        join_none

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_ready", pix_ready_o, 0);
        chk("idle_core_en", core_en_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);

        // Ramp frame, continuous valid
        for (int i = 0; i < NP; i++) frame[i] = DW'(4 * (i / W) + (i % W));
        seen_q.delete();
        en0 = en_seen; done0 = done_seen;
        pulse_start();
        chk("busy_after_start", busy_o, 1);
        send_range(0, NP, 0);
        finish_frame("ramp", en0, done0);
        if (seen_q.size() == 4) begin
            chk("first_d00", seen_q[0][71:64], 0);
            chk("first_d02", seen_q[0][55:48], 2);
            chk("first_d11", seen_q[0][39:32], 5);
            chk("first_d22", seen_q[0][7:0], 10);
            chk("last_d00", seen_q[3][71:64], 5);
            chk("last_d22", seen_q[3][7:0], 15);
        end else begin
            chk("ramp_window_count", seen_q.size(), 4);
        end

        // Random pixels, 50% valid gaps
        for (int i = 0; i < NP; i++) frame[i] = DW'($urandom);
        en0 = en_seen; done0 = done_seen;
        pulse_start();
        send_range(0, NP, 50);
        finish_frame("gaps", en0, done0);

        // Reset asserted after the pixel at row 2, col 1
        for (int i = 0; i < NP; i++) frame[i] = DW'($urandom_range(1, 255));
        pulse_start();
        send_range(0, 2 * W + 2, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", pix_ready_o, 0);
        chk("rst_core_en", core_en_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_window", win_bus, 0);
        chk("rst_no_windows_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Restarted frame after reset
        for (int i = 0; i < NP; i++) frame[i] = DW'($urandom);
        en0 = en_seen; done0 = done_seen;
        pulse_start();
        send_range(0, NP, 25);
        finish_frame("restart", en0, done0);

        // start_i pulsed mid-stream must be ignored
        for (int i = 0; i < NP; i++) frame[i] = DW'($urandom);
        en0 = en_seen; done0 = done_seen;
        pulse_start();
        send_range(0, 9, 30);
        pulse_start();
        chk("busy_after_restart_pulse", busy_o, 1);
        send_range(9, NP, 30);
        finish_frame("midstart", en0, done0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
